// File: rtl/biriscv_npc_pkg.sv
// Shared constants and types for the next-PC predictor.
// BHT counter encodings, BTB entry layout, instruction size.
package biriscv_npc_defs;

  localparam logic [1:0] BHT_STRONG_NT = 2'd0;
  localparam logic [1:0] BHT_WEAK_NT   = 2'd1;
  localparam logic [1:0] BHT_WEAK_T    = 2'd2;
  localparam logic [1:0] BHT_STRONG_T  = 2'd3;
  localparam logic [1:0] BHT_RESET     = BHT_WEAK_NT;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] INST_SIZE = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic            is_call;
    logic            is_ret;
    logic            is_jmp;
  } btb_entry_t;

endpackage

// File: rtl/biriscv_npc_if.sv
// Registered branch-resolution bus from execute to the predictor.
// master: execute side drives; slave: predictor samples.
interface biriscv_npc_if;

  logic        branch_request_i;
  logic        branch_is_taken_i;
  logic        branch_is_not_taken_i;
  logic [31:0] branch_source_i;
  logic [31:0] branch_pc_i;
  logic        branch_is_call_i;
  logic        branch_is_ret_i;
  logic        branch_is_jmp_i;

  modport master (
    output branch_request_i,
    output branch_is_taken_i,
    output branch_is_not_taken_i,
    output branch_source_i,
    output branch_pc_i,
    output branch_is_call_i,
    output branch_is_ret_i,
    output branch_is_jmp_i
  );

  modport slave (
    input branch_request_i,
    input branch_is_taken_i,
    input branch_is_not_taken_i,
    input branch_source_i,
    input branch_pc_i,
    input branch_is_call_i,
    input branch_is_ret_i,
    input branch_is_jmp_i
  );

endinterface

// File: rtl/biriscv_npc_ras.sv
// Return address stack, updated at branch resolution only.
// Ports: clk_i, rst_n, push_i/pop_i/push_pc_i in; valid_o/top_o out.
module biriscv_npc_ras
  import biriscv_npc_defs::*;
#(
  parameter int RAS_DEPTH   = 8,
  parameter int RAS_DEPTH_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_pc_i,
  output logic            valid_o,
  output logic [PC_W-1:0] top_o
);

  localparam logic [RAS_DEPTH_W:0] FULL =
    (RAS_DEPTH_W+1)'(RAS_DEPTH);

  logic [PC_W-1:0]        stack_q [RAS_DEPTH];
  logic [RAS_DEPTH_W-1:0] ptr_q;
  logic [RAS_DEPTH_W:0]   count_q;

  // ptr_q is the next free slot; top is one below it.
  assign top_o   = stack_q[ptr_q - RAS_DEPTH_W'(1)];
  assign valid_o = (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push_i) begin
      ptr_q <= ptr_q + RAS_DEPTH_W'(1);
      if (count_q != FULL)
        count_q <= count_q + (RAS_DEPTH_W+1)'(1);
    end else if (pop_i && valid_o) begin
      ptr_q   <= ptr_q - RAS_DEPTH_W'(1);
      count_q <= count_q - (RAS_DEPTH_W+1)'(1);
    end
  end

  // A full push simply overwrites the oldest slot.
  always_ff @(posedge clk_i) begin
    if (rst_n && push_i)
      stack_q[ptr_q] <= push_pc_i;
  end

endmodule

// File: rtl/biriscv_npc.sv
// Next-PC predictor: fully associative BTB, 2-bit BHT, RAS.
// Ports: clk_i, rst_n, pc_f_i, pc_accept_i, br, next_pc/taken out.
module biriscv_npc
  import biriscv_npc_defs::*;
#(
  parameter int SUPPORT_BRANCH_PREDICTION = 1,
  parameter int NUM_BTB_ENTRIES           = 32,
  parameter int NUM_BTB_ENTRIES_W         = 5,
  parameter int NUM_BHT_ENTRIES           = 512,
  parameter int NUM_BHT_ENTRIES_W         = 9,
  parameter int RAS_DEPTH                 = 8,
  parameter int RAS_DEPTH_W               = 3
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_f_i,
  input  logic            pc_accept_i,
  biriscv_npc_if.slave    br,
  output logic [PC_W-1:0] next_pc_f_o,
  output logic            next_taken_f_o
);

  localparam int BW = NUM_BTB_ENTRIES_W;
  localparam int HW = NUM_BHT_ENTRIES_W;

  btb_entry_t          btb_q [NUM_BTB_ENTRIES];
  logic [NUM_BTB_ENTRIES-1:0] btb_valid_q;
  logic [BW-1:0]       btb_ptr_q;
  logic [1:0]          bht_q [NUM_BHT_ENTRIES];

  logic                unused_ok;
  assign unused_ok = pc_accept_i;

  // Fetch-side lookup
  logic            lk_hit;
  logic [BW-1:0]   lk_idx;
  btb_entry_t      lk_e;
  logic [1:0]      lk_bht;
  logic [PC_W-1:0] pc_plus4;
  logic            ras_valid;
  logic [PC_W-1:0] ras_top;
  logic [PC_W-1:0] pred_pc;
  logic            pred_tk;
  logic            hit_ret;
  logic            hit_unc;
  logic            hit_cond;

  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
      if (btb_valid_q[i] && btb_q[i].pc == pc_f_i) begin
        lk_hit = 1'b1;
        lk_idx = BW'(i);
      end
    end
  end

  assign lk_e     = btb_q[lk_idx];
  assign lk_bht   = bht_q[pc_f_i[HW+1:2]];
  assign pc_plus4 = pc_f_i + INST_SIZE;

  // Ret wins over call/jmp if an entry somehow has both.
  assign hit_ret  = lk_hit & lk_e.is_ret;
  assign hit_unc  = lk_hit & ~lk_e.is_ret &
                    (lk_e.is_call | lk_e.is_jmp);
  assign hit_cond = lk_hit & ~lk_e.is_ret &
                    ~lk_e.is_call & ~lk_e.is_jmp;

  always_comb begin
    pred_pc = pc_plus4;
    pred_tk = 1'b0;
    unique case (1'b1)
      hit_ret: begin
        pred_tk = 1'b1;
        pred_pc = ras_valid ? ras_top : lk_e.target;
      end
      hit_unc: begin
        pred_tk = 1'b1;
        pred_pc = lk_e.target;
      end
      hit_cond: begin
        pred_tk = lk_bht[1];
        if (lk_bht[1])
          pred_pc = lk_e.target;
      end
      default: ;
    endcase
  end

  if (SUPPORT_BRANCH_PREDICTION != 0) begin : g_pred
    assign next_pc_f_o    = pred_pc;
    assign next_taken_f_o = pred_tk;
  end else begin : g_nopred
    assign next_pc_f_o    = pc_plus4;
    assign next_taken_f_o = 1'b0;
  end

  // Resolution-side update
  logic            wr_hit;
  logic [BW-1:0]   wr_idx;
  logic [BW-1:0]   wr_slot;
  btb_entry_t      wr_e;
  logic [HW-1:0]   bht_idx;
  logic [1:0]      bht_cur;
  logic            upd_t;
  logic            upd_nt;

  always_comb begin
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
      if (btb_valid_q[i] &&
          btb_q[i].pc == br.branch_source_i) begin
        wr_hit = 1'b1;
        wr_idx = BW'(i);
      end
    end
  end

  assign wr_slot = wr_hit ? wr_idx : btb_ptr_q;
  assign wr_e = '{
    pc:      br.branch_source_i,
    target:  br.branch_pc_i,
    is_call: br.branch_is_call_i,
    is_ret:  br.branch_is_ret_i,
    is_jmp:  br.branch_is_jmp_i
  };

  assign bht_idx = br.branch_source_i[HW+1:2];
  assign bht_cur = bht_q[bht_idx];
  assign upd_t   = br.branch_request_i &
                   br.branch_is_taken_i;
  assign upd_nt  = br.branch_request_i &
                   ~br.branch_is_taken_i &
                   br.branch_is_not_taken_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      btb_valid_q <= '0;
      btb_ptr_q   <= '0;
      for (int i = 0; i < NUM_BHT_ENTRIES; i++)
        bht_q[i] <= BHT_RESET;
    end else begin
      if (upd_t && bht_cur != BHT_STRONG_T)
        bht_q[bht_idx] <= bht_cur + 2'd1;
      else if (upd_nt && bht_cur != BHT_STRONG_NT)
        bht_q[bht_idx] <= bht_cur - 2'd1;
      if (upd_t && !wr_hit) begin
        btb_valid_q[btb_ptr_q] <= 1'b1;
        btb_ptr_q <= btb_ptr_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n && upd_t)
      btb_q[wr_slot] <= wr_e;
  end

  logic ras_push;
  logic ras_pop;

  // Call has priority when both are flagged.
  assign ras_push = br.branch_request_i &
                    br.branch_is_call_i;
  assign ras_pop  = br.branch_request_i &
                    br.branch_is_ret_i &
                    ~br.branch_is_call_i;

  biriscv_npc_ras #(
    .RAS_DEPTH   (RAS_DEPTH),
    .RAS_DEPTH_W (RAS_DEPTH_W)
  ) u_ras (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .push_i    (ras_push),
    .pop_i     (ras_pop),
    .push_pc_i (br.branch_source_i + INST_SIZE),
    .valid_o   (ras_valid),
    .top_o     (ras_top)
  );

endmodule

// File: tb/tb_biriscv_npc.sv
// Randomized bench for biriscv_npc against a queue-based model.
// Runs a predicting and a non-predicting instance in parallel.
module tb_biriscv_npc;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_f_i = '0;
  logic        pc_accept_i = 1'b0;
  logic [31:0] npc_p, npc_n;
  logic        tk_p, tk_n;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  biriscv_npc_if bif ();

  biriscv_npc u_dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .pc_f_i         (pc_f_i),
    .pc_accept_i    (pc_accept_i),
    .br             (bif.slave),
    .next_pc_f_o    (npc_p),
    .next_taken_f_o (tk_p)
  );

  biriscv_npc #(
    .SUPPORT_BRANCH_PREDICTION (0)
  ) u_nop (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .pc_f_i         (pc_f_i),
    .pc_accept_i    (pc_accept_i),
    .br             (bif.slave),
    .next_pc_f_o    (npc_n),
    .next_taken_f_o (tk_n)
  );

  // Model: BTB as a map plus allocation-order queue,
  // RAS as a bounded queue, BHT as a sparse map.
  typedef struct {
    logic [31:0] target;
    bit          call;
    bit          ret;
    bit          jmp;
  } m_btb_t;

  m_btb_t      m_btb [bit [31:0]];
  bit [31:0]   m_alloc [$];
  bit [31:0]   m_ras [$];
  int          m_bht [int];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_btb.delete();
    m_alloc.delete();
    m_ras.delete();
    m_bht.delete();
  endfunction

  function automatic int m_bht_rd(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) % 512);
    return m_bht.exists(idx) ? m_bht[idx] : 1;
  endfunction

  task automatic m_predict(input logic [31:0] pc,
                           output logic [31:0] npc,
                           output logic tk);
    m_btb_t e;
    npc = pc + 32'd4;
    tk  = 1'b0;
    if (m_btb.exists(pc)) begin
      e = m_btb[pc];
      if (e.ret) begin
        tk  = 1'b1;
        npc = (m_ras.size() > 0) ? m_ras[$] : e.target;
      end else if (e.call || e.jmp) begin
        tk  = 1'b1;
        npc = e.target;
      end else if (m_bht_rd(pc) >= 2) begin
        tk  = 1'b1;
        npc = e.target;
      end
    end
  endtask

  task automatic m_update();
    logic [31:0] src;
    bit [31:0]   old;
    int          idx;
    int          c;
    m_btb_t      e;
    if (!bif.branch_request_i) return;
    src = bif.branch_source_i;
    idx = int'((src >> 2) % 512);
    c   = m_bht_rd(src);
    if (bif.branch_is_taken_i)
      m_bht[idx] = (c < 3) ? c + 1 : 3;
    else if (bif.branch_is_not_taken_i)
      m_bht[idx] = (c > 0) ? c - 1 : 0;
    if (bif.branch_is_taken_i) begin
      e.target = bif.branch_pc_i;
      e.call   = bif.branch_is_call_i;
      e.ret    = bif.branch_is_ret_i;
      e.jmp    = bif.branch_is_jmp_i;
      if (!m_btb.exists(src)) begin
        m_alloc.push_back(src);
        if (m_alloc.size() > 32) begin
          old = m_alloc.pop_front();
          m_btb.delete(old);
        end
      end
      m_btb[src] = e;
    end
    if (bif.branch_is_call_i) begin
      m_ras.push_back(src + 32'd4);
      if (m_ras.size() > 8)
        void'(m_ras.pop_front());
    end else if (bif.branch_is_ret_i && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endtask

  task automatic drive(input bit req, input bit tk,
                       input bit nt,
                       input logic [31:0] src,
                       input logic [31:0] tgt,
                       input bit call, input bit ret,
                       input bit jmp);
    bif.branch_request_i      = req;
    bif.branch_is_taken_i     = tk;
    bif.branch_is_not_taken_i = nt;
    bif.branch_source_i       = src;
    bif.branch_pc_i           = tgt;
    bif.branch_is_call_i      = call;
    bif.branch_is_ret_i       = ret;
    bif.branch_is_jmp_i       = jmp;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  task automatic clk_step();
    @(posedge clk_i);
    if (!rst_n) m_reset();
    else m_update();
    #1;
  endtask

  task automatic look(input logic [31:0] pc,
                      input string tag);
    logic [31:0] e_pc;
    logic        e_tk;
    pc_f_i = pc;
    #1;
    m_predict(pc, e_pc, e_tk);
    chk({tag, "_pc"}, npc_p, e_pc);
    chk({tag, "_tk"}, {31'd0, tk_p}, {31'd0, e_tk});
    chk({tag, "_nop_pc"}, npc_n, pc + 32'd4);
    chk({tag, "_nop_tk"}, {31'd0, tk_n}, 32'd0);
  endtask

  task automatic look_lit(input logic [31:0] pc,
                          input string tag,
                          input logic [31:0] x_pc,
                          input bit x_tk);
    look(pc, tag);
    chk({tag, "_lit_pc"}, npc_p, x_pc);
    chk({tag, "_lit_tk"}, {31'd0, tk_p}, {31'd0, x_tk});
  endtask

  task automatic resolve(input logic [31:0] src,
                         input logic [31:0] tgt,
                         input bit tk, input bit call,
                         input bit ret, input bit jmp);
    drive(1, tk, !tk, src, tgt, call, ret, jmp);
    clk_step();
    idle();
  endtask

  initial begin
    logic [31:0] src, tgt, pc;
    bit          req, tk, nt;
    int          typ;

    idle();
    rst_n  = 1'b0;
    pc_f_i = 32'h8000_0000;
    clk_step();
    clk_step();
    look_lit(32'h8000_0000, "rst", 32'h8000_0004, 0);
    rst_n = 1'b1;

    drive(1, 1, 0, 32'h100, 32'h200, 0, 0, 1);
    look_lit(32'h100, "jal_same", 32'h104, 0);
    clk_step();
    idle();
    look_lit(32'h100, "jal_next", 32'h200, 1);

    resolve(32'h300, 32'h340, 1, 0, 0, 0);
    look_lit(32'h300, "bht_t1", 32'h340, 1);
    resolve(32'h300, 32'h304, 0, 0, 0, 0);
    look_lit(32'h300, "bht_nt1", 32'h304, 0);
    repeat (4) resolve(32'h300, 32'h340, 1, 0, 0, 0);
    resolve(32'h300, 32'h304, 0, 0, 0, 0);
    look_lit(32'h300, "bht_sat", 32'h340, 1);

    resolve(32'h600, 32'h999, 1, 0, 1, 0);
    resolve(32'h400, 32'h800, 1, 1, 0, 0);
    resolve(32'h500, 32'h800, 1, 1, 0, 0);
    look_lit(32'h600, "ras1", 32'h504, 1);
    resolve(32'h600, 32'h999, 1, 0, 1, 0);
    look_lit(32'h600, "ras2", 32'h404, 1);
    resolve(32'h600, 32'h999, 1, 0, 1, 0);
    look_lit(32'h600, "ras_empty", 32'h999, 1);

    for (int k = 0; k < 33; k++) begin
      src = 32'h1000 + 32'(8 * k);
      resolve(src, src + 32'h40, 1, 0, 0, 1);
    end
    look_lit(32'h1000, "repl_first", 32'h1004, 0);
    look_lit(32'h1100, "repl_last", 32'h1140, 1);
    look_lit(32'hFFFF_FFFC, "wrap", 32'h0, 0);

    drive(1, 1, 0, 32'h3000, 32'h3100, 0, 0, 1);
    rst_n = 1'b0;
    clk_step();
    idle();
    rst_n = 1'b1;
    look_lit(32'h8000_0000, "rst_mid", 32'h8000_0004, 0);
    look_lit(32'h1100, "rst_mid_btb", 32'h1104, 0);
    look_lit(32'h3000, "rst_mid_upd", 32'h3004, 0);
    look_lit(32'h300, "rst_mid_bht", 32'h304, 0);

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom % 400 == 0) ? 1'b0 : 1'b1;
      typ = int'($urandom % 4);
      src = 32'h2000 + 32'(4 * $urandom_range(0, 47));
      req = ($urandom % 10) < 7;
      if (typ == 0) begin
        tk = $urandom % 2;
        nt = !tk;
        if ($urandom % 16 == 0) nt = 1'b1;
      end else begin
        tk = 1'b1;
        nt = 1'b0;
      end
      tgt = tk ? 32'h4000 + 32'(4 * ($urandom % 256))
               : src + 32'd4;
      drive(req, tk, nt, src, tgt,
            typ == 1, typ == 2, typ == 3);
      if ($urandom % 8 == 0)
        pc = 32'($urandom) & 32'hFFFF_FFFC;
      else
        pc = 32'h2000 + 32'(4 * $urandom_range(0, 47));
      look(pc, "rnd");
      clk_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
